// File: rtl/adc_sample_buf.sv
// Block-averaging ADC sample buffer: 2^avg_log2 sample averager feeding a synchronous FIFO.
// Optional drop counter enabled by defining ADC_BUF_OVF_CNT_EN.
module adc_sample_buf #(
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic [31:0]           din,
   input  logic                  din_valid,
   input  logic                  enable,
   input  logic [2:0]            avg_log2,
   input  logic                  flush,
   input  logic                  rd_en,
   output logic [31:0]           dout,
   output logic                  dout_valid,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  ovf,
   output logic [15:0]           ovf_cnt
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic signed [38:0] acc, sum;
   logic [6:0]         blk_cnt, blk_last;
   logic [2:0]         shift_rg, shift_eff;
   logic               push_rg;
   logic [31:0]        res_rg;
   logic [31:0]        mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
   logic               pop, wr;

   // the first sample of a block uses the live avg_log2, since shift_rg only latches it that cycle
   assign shift_eff = (blk_cnt == 7'd0) ? avg_log2 : shift_rg;
   assign blk_last  = 7'((8'd1 << shift_eff) - 8'd1);
   assign sum       = acc + {{7{din[31]}}, din};

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         acc      <= '0;
         blk_cnt  <= '0;
         shift_rg <= '0;
         push_rg  <= 1'b0;
         res_rg   <= '0;
      end else if (flush) begin
         acc     <= '0;
         blk_cnt <= '0;
         push_rg <= 1'b0;
      end else begin
         push_rg <= 1'b0;
         if (din_valid && blk_cnt == 7'd0)
            shift_rg <= avg_log2;
         if (!enable) begin
            acc     <= '0;
            blk_cnt <= '0;
         end else if (din_valid) begin
            if (blk_cnt == blk_last) begin
               res_rg  <= 32'(sum >>> shift_eff);
               push_rg <= 1'b1;
               acc     <= '0;
               blk_cnt <= '0;
            end else begin
               acc     <= sum;
               blk_cnt <= blk_cnt + 7'd1;
            end
         end
      end
   end

   assign level = wr_ptr - rd_ptr;
   assign empty = (level == '0);
   assign full  = level[DEPTH_LOG2];
   assign pop   = rd_en && !empty;
   // a full FIFO still accepts the push when the same edge frees a slot
   assign wr    = push_rg && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr && !flush)
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= res_rg;
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         ovf        <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         dout_valid <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         dout_valid <= pop;
         if (pop) begin
            dout   <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr)
            wr_ptr <= wr_ptr + 1'b1;
         else if (push_rg)
            ovf <= 1'b1;
      end
   end

`ifdef ADC_BUF_OVF_CNT_EN
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn)
         ovf_cnt <= '0;
      else if (flush)
         ovf_cnt <= '0;
      else if (push_rg && !wr && ovf_cnt != 16'hFFFF)
         ovf_cnt <= ovf_cnt + 16'd1;
   end
`else
   assign ovf_cnt = '0;
`endif

endmodule
